// File: rtl/dt_ticks_player.sv
// dt_ticks_player: captures the dtTicks table and replays it as laser pulses on each mirror zc edge
module dt_ticks_player #(
    parameter int FRAME_COLUMNS_P = 360,
    parameter int PULSE_LENGTH_P  = 5,
    parameter int DATA_W_P        = 16,
    parameter int ADDR_W_P        = 11
) (
    input  logic                clk_r,
    input  logic                nrst_r,
    input  logic                wedata_dtTicks_i,
    input  logic [DATA_W_P-1:0] wdata_dtTicks_i,
    input  logic [ADDR_W_P-1:0] waddr_dtTicks_i,
    input  logic                zc_i,
    input  logic                enable_i,
    output logic                laser_trigger_o,
    output logic [ADDR_W_P-1:0] point_idx_o,
    output logic                busy_o,
    output logic                sweep_done_o,
    output logic                table_ready_o,
    output logic                overrun_o
);
    localparam int RAW = $clog2(FRAME_COLUMNS_P);
    localparam int PW  = $clog2(PULSE_LENGTH_P + 1);
    localparam logic [ADDR_W_P-1:0] LAST = ADDR_W_P'(FRAME_COLUMNS_P - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT, FIRE} state_t;

    state_t              state, state_n;
    logic [DATA_W_P-1:0] ram [FRAME_COLUMNS_P];
    logic [DATA_W_P-1:0] rd_data, cnt, cnt_n;
    logic [ADDR_W_P-1:0] idx, idx_n;
    logic [PW-1:0]       pcnt, pcnt_n;
    logic                zc_d, zc_edge, dir, dir_n, start, last_pt, done_n, ovr_n;

    // RAM is not reset; read-during-write returns the old word
    always_ff @(posedge clk_r) begin
        if (wedata_dtTicks_i && waddr_dtTicks_i < ADDR_W_P'(FRAME_COLUMNS_P))
            ram[waddr_dtTicks_i[RAW-1:0]] <= wdata_dtTicks_i;
        if (state == FETCH)
            rd_data <= ram[idx[RAW-1:0]];
    end

    always_comb begin
        zc_edge = zc_i ^ zc_d;
        last_pt = dir ? (idx == LAST) : (idx == '0);
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        pcnt_n  = pcnt;
        dir_n   = dir;
        done_n  = 1'b0;
        ovr_n   = overrun_o;
        start   = 1'b0;
        case (state)
            IDLE:  start = zc_edge && enable_i && table_ready_o;
            FETCH: state_n = LOAD;
            LOAD: begin
                state_n = WAIT;
                cnt_n   = rd_data;
            end
            WAIT: begin
                state_n = (cnt == '0) ? FIRE : WAIT;
                pcnt_n  = (cnt == '0) ? PW'(PULSE_LENGTH_P) : pcnt;
                cnt_n   = (cnt == '0) ? cnt : cnt - DATA_W_P'(1);
            end
            FIRE: begin
                pcnt_n = pcnt - PW'(1);
                if (pcnt == PW'(1)) begin
                    state_n = (last_pt || !enable_i) ? IDLE : FETCH;
                    done_n  = last_pt;
                    idx_n   = (last_pt || !enable_i) ? idx : (dir ? idx + ADDR_W_P'(1) : idx - ADDR_W_P'(1));
                end
            end
            default: state_n = IDLE;
        endcase
        // an edge mid-sweep aborts it and optionally restarts in the new direction
        if (state != IDLE && zc_edge) begin
            ovr_n   = 1'b1;
            done_n  = 1'b0;
            state_n = IDLE;
            start   = enable_i;
        end
        if (start) begin
            state_n = FETCH;
            dir_n   = zc_i;
            idx_n   = zc_i ? '0 : LAST;
        end
    end

    always_ff @(posedge clk_r or negedge nrst_r) begin
        if (!nrst_r) begin
            state         <= IDLE;
            zc_d          <= 1'b0;
            idx           <= '0;
            cnt           <= '0;
            pcnt          <= '0;
            dir           <= 1'b0;
            sweep_done_o  <= 1'b0;
            overrun_o     <= 1'b0;
            table_ready_o <= 1'b0;
        end else begin
            state         <= state_n;
            zc_d          <= zc_i;
            idx           <= idx_n;
            cnt           <= cnt_n;
            pcnt          <= pcnt_n;
            dir           <= dir_n;
            sweep_done_o  <= done_n;
            overrun_o     <= ovr_n;
            table_ready_o <= table_ready_o | (wedata_dtTicks_i && waddr_dtTicks_i == LAST);
        end
    end

    assign laser_trigger_o = state == FIRE;
    assign busy_o          = state != IDLE;
    assign point_idx_o     = idx;
endmodule

// File: tb/tb_dt_ticks_player.sv
// tb_dt_ticks_player: directed and randomized checks against a pulse-schedule model of dt_ticks_player
`timescale 1ns/1ps
module tb_dt_ticks_player;
    localparam int N  = 4;
    localparam int P  = 5;
    localparam int DW = 16;
    localparam int AW = 11;

    logic          clk_r = 1'b0;
    logic          nrst_r = 1'b0;
    logic          we = 1'b0;
    logic          zc = 1'b0;
    logic          en = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [AW-1:0] waddr = '0;
    logic          trig, busy, done, ready, ovr;
    logic [AW-1:0] pidx;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // schedule model: a sweep is a list of absolute pulse-rise cycles
    int tbl [N];
    int rise [N];
    bit m_active, m_dir, m_ready, m_ovr, zc_prev;
    int m_e, m_end, m_done, last_idx;
    int rises [$];
    int done_at;
    logic trig_prev = 1'b0;

    dt_ticks_player #(
        .FRAME_COLUMNS_P(N),
        .PULSE_LENGTH_P (P),
        .DATA_W_P       (DW),
        .ADDR_W_P       (AW)
    ) dut (
        .clk_r           (clk_r),
        .nrst_r          (nrst_r),
        .wedata_dtTicks_i(we),
        .wdata_dtTicks_i (wdata),
        .waddr_dtTicks_i (waddr),
        .zc_i            (zc),
        .enable_i        (en),
        .laser_trigger_o (trig),
        .point_idx_o     (pidx),
        .busy_o          (busy),
        .sweep_done_o    (done),
        .table_ready_o   (ready),
        .overrun_o       (ovr)
    );

    always #5 clk_r = ~clk_r;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_dir    = 0;
        m_ready  = 0;
        m_ovr    = 0;
        zc_prev  = 0;
        m_e      = 0;
        m_end    = 0;
        m_done   = -1;
        last_idx = 0;
    endtask

    task automatic start_sweep(input int e, input bit d);
        int t;
        m_active = 1;
        m_e      = e;
        m_dir    = d;
        t        = e + 4;
        for (int k = 0; k < N; k++) begin
            t      += tbl[d ? k : N - 1 - k];
            rise[k] = t;
            t      += P + 3;
        end
        m_end  = rise[N-1] + P;
        m_done = m_end;
    endtask

    function automatic bit m_busy(input int c);
        return m_active && c > m_e && c < m_end;
    endfunction

    function automatic int m_point(input int c);
        for (int k = 0; k < N; k++)
            if (c < rise[k] + P) return k;
        return N - 1;
    endfunction

    task automatic tick();
        bit b, t, e;
        int k, ix;
        @(negedge clk_r);
        if (!nrst_r) model_reset();
        b  = m_busy(cyc);
        k  = b ? m_point(cyc) : 0;
        t  = b && cyc >= rise[k];
        ix = b ? (m_dir ? k : N - 1 - k) : last_idx;
        chk("busy", busy, b);
        chk("trig", trig, t);
        chk("idx", pidx, ix);
        chk("done", done, cyc == m_done);
        chk("ready", ready, m_ready);
        chk("ovr", ovr, m_ovr);
        if (trig && !trig_prev) rises.push_back(cyc);
        if (done) done_at = cyc;
        trig_prev = trig;
        if (nrst_r) begin
            e = zc != zc_prev;
            if (we && waddr < N) tbl[waddr] = wdata;
            if (b) last_idx = ix;
            if (b && e) begin
                m_ovr  = 1;
                m_end  = cyc + 1;
                m_done = -1;
                if (en) start_sweep(cyc, zc);
            end else if (!b && e && en && m_ready) begin
                start_sweep(cyc, zc);
            end else if (t && cyc == rise[k] + P - 1 && k != N - 1 && !en) begin
                m_end  = cyc + 1;
                m_done = -1;
            end
            if (we && waddr == N - 1) m_ready = 1;
            zc_prev = zc;
        end
        @(posedge clk_r);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input int a, input int d);
        we    = 1;
        waddr = AW'(a);
        wdata = DW'(d);
        tick();
        we    = 0;
    endtask

    task automatic async_reset();
        nrst_r = 0;
        #1;
        chk("arst_trig", trig, 0);
        chk("arst_busy", busy, 0);
        chk("arst_idx", pidx, 0);
        chk("arst_done", done, 0);
        chk("arst_ready", ready, 0);
        chk("arst_ovr", ovr, 0);
        idle(3);
        nrst_r = 1;
    endtask

    int e0;

    initial begin
        for (int i = 0; i < N; i++) tbl[i] = 0;
        model_reset();
        done_at = -1;
        @(posedge clk_r);
        #1;
        idle(3);
        nrst_r = 1;
        idle(2);
        // incomplete table: edge is ignored; out-of-range write is dropped
        en = 1;
        wr(0, 2);
        wr(1, 0);
        wr(2, 7);
        zc = 1;
        idle(12);
        chk("gate_no_pulse", rises.size(), 0);
        chk("gate_not_ready", ready, 0);
        wr(4, 99);
        chk("gate_addr4_ignored", ready, 0);
        wr(3, 1);
        chk("gate_ready", ready, 1);
        en = 0;
        zc = 0;
        idle(10);
        chk("en0_edge_ignored", busy, 0);
        // forward sweep
        en = 1;
        zc = 1;
        e0 = cyc;
        rises.delete();
        done_at = -1;
        idle(60);
        chk("fwd_count", rises.size(), 4);
        chk("fwd_rise0", rises.size() > 0 ? rises[0] - e0 : -1, 6);
        chk("fwd_rise1", rises.size() > 1 ? rises[1] - e0 : -1, 14);
        chk("fwd_rise2", rises.size() > 2 ? rises[2] - e0 : -1, 29);
        chk("fwd_rise3", rises.size() > 3 ? rises[3] - e0 : -1, 38);
        chk("fwd_done", done_at - e0, 43);
        // reverse sweep
        zc = 0;
        e0 = cyc;
        rises.delete();
        done_at = -1;
        idle(60);
        chk("rev_rise0", rises.size() > 0 ? rises[0] - e0 : -1, 5);
        chk("rev_rise1", rises.size() > 1 ? rises[1] - e0 : -1, 20);
        chk("rev_done", done_at - e0, 43);
        // enable dropped during FIRE of point 1
        zc = 1;
        e0 = cyc;
        idle(15);
        en = 0;
        done_at = -1;
        rises.delete();
        idle(20);
        chk("en_busy", busy, 0);
        chk("en_no_done", done_at, -1);
        chk("en_no_more_pulses", rises.size(), 0);
        zc = 0;
        idle(10);
        chk("en_edge_ignored", busy, 0);
        // overrun with long ticks
        en = 1;
        for (int i = 0; i < N; i++) wr(i, 100);
        zc = 1;
        idle(150);
        zc = 0;
        done_at = -1;
        idle(100);
        chk("ovr_no_done", done_at, -1);
        chk("ovr_sticky", ovr, 1);
        idle(400);
        chk("ovr_restart_done", done_at > 0, 1);
        chk("ovr_still_set", ovr, 1);
        // reset mid-sweep
        for (int i = 0; i < N; i++) wr(i, $urandom_range(0, 6));
        zc = 1;
        idle(10);
        async_reset();
        rises.delete();
        idle(30);
        chk("rst_no_pulse", rises.size(), 0);
        for (int i = 0; i < N; i++) wr(i, $urandom_range(0, 12));
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            en = $urandom_range(0, 19) != 0;
            if ($urandom_range(0, 69) == 0) zc = ~zc;
            we = 0;
            if (!m_busy(cyc) && $urandom_range(0, 3) == 0) begin
                we    = 1;
                waddr = AW'($urandom_range(0, 5));
                wdata = DW'($urandom_range(0, 12));
            end
            tick();
        end
        we = 0;
        idle(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dt_ticks_player.md
Name: dt_ticks_player

Overview:
- Consumer end of the dtTicks write interface produced by laserSynchronizer.
- Captures the per-point delta-tick table into local RAM, then replays it on every mirror zero-crossing edge to fire laser pulses.
- Rising zc edge sweeps forward (point 0..N-1); falling zc edge sweeps in reverse (point N-1..0).
- Sits between the tick generator and the laser driver. It also serves as the reference checker for tick tables.

Parameters:
- FRAME_COLUMNS_P, 360: points per sweep; RAM depth.
- PULSE_LENGTH_P, 5: laser pulse width in clk_r cycles (≥1).
- DATA_W_P, 16: tick value width.
- ADDR_W_P, 11: address width.

Ports:
- clk_r  in  1  system clock.
- nrst_r  in  1  asynchronous active-low reset.
- wedata_dtTicks_i  in  1  table write enable.
- wdata_dtTicks_i  in  DATA_W_P  tick value.
- waddr_dtTicks_i  in  ADDR_W_P  point index.
- zc_i  in  1  mirror zero-crossing level, synchronous to clk_r.
- enable_i  in  1  playback enable.
- laser_trigger_o  out  1  laser pulse.
- point_idx_o  out  ADDR_W_P  current point index.
- busy_o  out  1  sweep in progress.
- sweep_done_o  out  1  one-cycle pulse on normal sweep completion.
- table_ready_o  out  1  full table loaded.
- overrun_o  out  1  sticky; zc edge arrived during a sweep.

Behaviour:
- Reset: clk_r clock; reset nrst_r, asynchronous, active-low. On reset, all outputs are 0, the FSM goes to IDLE, and zc_d is loaded with 0. RAM contents are not reset.
- Write port:
  - When wedata_dtTicks_i=1 and waddr < FRAME_COLUMNS_P, RAM[waddr] is written at the clock edge.
  - Writes with waddr ≥ FRAME_COLUMNS_P are ignored.
  - A write to FRAME_COLUMNS_P-1 sets table_ready_o on the next cycle. Only reset clears it.
  - Writes during playback are allowed. The read is synchronous; read-during-write to the same address returns the old data.
- Edge detect:
  - zc_d is a register of zc_i.
  - edge = zc_i ^ zc_d; direction = zc_i (1 = forward, 0 = reverse). E is the cycle in which edge=1.
- FSM states: IDLE, FETCH, LOAD, WAIT, FIRE.
  - IDLE: on edge with enable_i=1 and table_ready_o=1, set idx to 0 (forward) or FRAME_COLUMNS_P-1 (reverse), then go to FETCH. An edge is ignored otherwise.
  - FETCH: issue RAM read at idx, then go to LOAD.
  - LOAD: cnt = RAM data, then go to WAIT.
  - WAIT: if cnt==0, go to FIRE with pulse counter = PULSE_LENGTH_P; else cnt--.
  - FIRE: laser_trigger_o=1 for exactly PULSE_LENGTH_P cycles. On the last cycle:
    - if idx is the final point, assert sweep_done_o on the next cycle and go to IDLE;
    - else if enable_i=0, go to IDLE with no sweep_done_o;
    - else step idx ±1 and go to FETCH.
- Timing (exact):
  - First pulse rises in cycle E+4+D0, where D0 is the tick value of the first point.
  - Each following rise = previous rise + PULSE_LENGTH_P + 3 + D_k.
  - D=0 is legal.
  - Total sweep length = Σ(D_k) + N·(PULSE_LENGTH_P+3) + 1.
- Outputs:
  - busy_o=1 in every state except IDLE.
  - point_idx_o = idx while busy_o=1; it holds its last value otherwise.
- Overrun: an edge while busy_o=1 sets overrun_o, which stays set until reset. In the next cycle:
  - laser_trigger_o drops (a truncated pulse is allowed);
  - no sweep_done_o is emitted;
  - if enable_i=1, a new sweep starts (re-initialise idx/direction, go to FETCH); else go to IDLE.
- Arithmetic: cnt is DATA_W_P bits, decrement only, and never wraps (WAIT leaves at 0). idx stays in the range 0..FRAME_COLUMNS_P-1.
- Reset mid-operation: laser_trigger_o falls asynchronously. After release, an edge is detected only if zc_i is 1, because zc_d reset to 0.

Test Plan:
- Reset value check: assert nrst_r=0 mid-stream -> every output is 0 asynchronously; after release, no pulse fires while zc_i is held constant.
- Forward sweep: FRAME_COLUMNS_P=4, PULSE_LENGTH_P=5, table {2,0,7,1}, zc 0→1 at E -> rises at E+6, E+14, E+29, E+38; widths 5; point_idx 0,1,2,3; sweep_done_o at E+43.
- Reverse sweep: same table, zc 1→0 -> order idx 3,2,1,0; first rise at E+5, next at E+20 (D=7).
- Table gating:
  - writes to addresses 0..2 only, then an edge -> no pulse, table_ready_o=0;
  - write to waddr=4 -> ignored;
  - write to addr 3 -> table_ready_o=1 next cycle.
- Overrun: table all 100, toggle zc mid-sweep -> overrun_o=1 sticky, trigger low next cycle, new sweep in the new direction, no sweep_done_o for the aborted sweep.
- Enable: clear enable_i during FIRE of point 1 -> pulse completes its 5 cycles, FSM goes to IDLE, busy_o=0, no sweep_done_o; an edge with enable_i=0 is ignored.
